// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;
  localparam int   CNT_W  = 4;
endpackage

// File: rtl/mem_latency_timer.sv
// Load/decrement down-counter emulating memory access latency; zero marks the final cycle.
module mem_latency_timer
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data_memory between icache and dcache ports,
// with an emulated multi-cycle access latency and one-cycle ready pulses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_en,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read_en,
  input  logic              dc_write_en,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_op_wr;
  logic              r_busy;
  logic              r_ic_ready;
  logic              r_dc_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dc_rdata;

  logic w_ic_req;
  logic w_dc_req;
  logic w_grant;
  logic w_grant_dc;
  logic w_zero;

  // In DONE the just-served requester is still sampling its old request, so it
  // is masked; the other side can be granted at once for LATENCY+1 throughput.
  always_comb begin
    w_ic_req = ic_read_en;
    w_dc_req = dc_read_en | dc_write_en;
    if (r_state == DONE) begin
      if (r_owner == OWN_IC) w_ic_req = 1'b0;
      else                   w_dc_req = 1'b0;
    end
    w_grant    = (r_state != BUSY) && (w_ic_req || w_dc_req);
    w_grant_dc = w_dc_req && (!w_ic_req || (r_owner == OWN_IC));
  end

  mem_latency_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_grant),
    .load_val (LOAD_VAL),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IC;
      r_op_wr    <= 1'b0;
      r_busy     <= 1'b0;
      r_ic_ready <= 1'b0;
      r_dc_ready <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      r_ic_ready <= 1'b0;
      r_dc_ready <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_grant) begin
            r_state <= BUSY;
            r_busy  <= 1'b1;
            r_owner <= w_grant_dc ? OWN_DC : OWN_IC;
            r_op_wr <= w_grant_dc && dc_write_en;
            r_addr  <= w_grant_dc ? dc_addr : ic_addr;
            if (w_grant_dc) r_wdata <= dc_wdata;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        BUSY: begin
          if (w_zero) begin
            r_state <= DONE;
            if (r_owner == OWN_DC) begin
              r_dc_ready <= 1'b1;
              if (!r_op_wr) r_dc_rdata <= mem_rdata;
            end else begin
              r_ic_ready <= 1'b1;
              r_ic_rdata <= mem_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_write_en = (r_state == BUSY) && w_zero && r_op_wr;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign ic_rdata     = r_ic_rdata;
  assign dc_rdata     = r_dc_rdata;
  assign ic_ready     = r_ic_ready;
  assign dc_ready     = r_dc_ready;
  assign busy         = r_busy;
  assign owner        = r_owner;
endmodule
